// File: rtl/iserdes_word_align.sv
// Purpose: aligns raw deserializer words to the training pattern by searching the 8 bit offsets.
// Latency: din to dout is 2 valid words + 1 clkPara cycle; lock decisions are made on each valid word.
// Backpressure: none; dinValid qualifies input, and nothing advances while dinValid=0 except realign.
//
// Ports:
//   clkPara, resetN          - parallel-word clock, async active-low reset
//   din, dinValid            - raw unaligned word (din[7] earliest bit) and its qualifier
//   trainEn                  - far end is sending TRAIN_PATTERN (enables error checking when locked)
//   realign                  - single-cycle request to drop lock and restart the search
//   dout, doutValid          - aligned word (MSB earliest) and qualifier
//   locked, offset           - lock status and bit offset in use
//   lossOfLock               - one-cycle pulse on every LOCKED->SEARCH transition
module iserdes_word_align #(
    parameter logic [7:0]  TRAIN_PATTERN = 8'hA5,
    parameter int unsigned LOCK_COUNT    = 16,
    parameter int unsigned UNLOCK_ERRS   = 4
) (
    input  logic       clkPara,
    input  logic       resetN,
    input  logic [7:0] din,
    input  logic       dinValid,
    input  logic       trainEn,
    input  logic       realign,
    output logic [7:0] dout,
    output logic       doutValid,
    output logic       locked,
    output logic [2:0] offset,
    output logic       lossOfLock
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e     state_q;
    logic [2:0] offset_q;
    logic [7:0] wprev_q;
    logic [7:0] wcur_q;
    logic [7:0] match_cnt_q;
    logic [3:0] err_cnt_q;
    logic       skip_q;
    logic       loss_q;
    logic       upd_q;
    logic [7:0] dout_q;
    logic       dout_vld_q;

    // The FSM judges the window the history will hold after this valid word is
    // taken in, i.e. {wCur, din}; dout shows the same window one cycle later
    // once it sits in {wPrev, wCur}.
    logic [15:0] eval_sh;
    logic [7:0]  eval_win;
    logic        eval_match;
    logic [15:0] hist_sh;
    logic [7:0]  hist_win;
    logic [7:0]  match_cnt_inc;
    logic [3:0]  err_cnt_inc;

    always_comb begin
        eval_sh       = {wcur_q, din} << offset_q;
        eval_win      = eval_sh[15:8];
        eval_match    = (eval_win == TRAIN_PATTERN);
        hist_sh       = {wprev_q, wcur_q} << offset_q;
        hist_win      = hist_sh[15:8];
        match_cnt_inc = (match_cnt_q == 8'hFF) ? 8'hFF : match_cnt_q + 8'd1;
        err_cnt_inc   = (err_cnt_q == 4'hF) ? 4'hF : err_cnt_q + 4'd1;
    end

    // Alignment FSM. skip_q marks the first valid word after entering SEARCH,
    // which only refills history and is never judged.
    always_ff @(posedge clkPara or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_SEARCH;
            offset_q    <= 3'd0;
            match_cnt_q <= 8'd0;
            err_cnt_q   <= 4'd0;
            skip_q      <= 1'b1;
            loss_q      <= 1'b0;
        end else begin
            loss_q <= 1'b0;
            if (realign) begin
                // Overrides any data-driven transition and ignores dinValid.
                loss_q      <= (state_q == ST_LOCKED);
                state_q     <= ST_SEARCH;
                match_cnt_q <= 8'd0;
                err_cnt_q   <= 4'd0;
                skip_q      <= 1'b1;
            end else if (dinValid) begin
                case (state_q)
                    ST_SEARCH: begin
                        if (skip_q) begin
                            skip_q <= 1'b0;
                        end else if (eval_match) begin
                            match_cnt_q <= 8'd1;
                            state_q     <= (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
                        end else begin
                            offset_q <= offset_q + 3'd1;
                        end
                    end
                    ST_VERIFY: begin
                        if (eval_match) begin
                            match_cnt_q <= match_cnt_inc;
                            if (32'(match_cnt_inc) >= LOCK_COUNT) begin
                                state_q <= ST_LOCKED;
                            end
                        end else begin
                            state_q     <= ST_SEARCH;
                            offset_q    <= offset_q + 3'd1;
                            match_cnt_q <= 8'd0;
                            skip_q      <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (!trainEn || eval_match) begin
                            err_cnt_q <= 4'd0;
                        end else if (32'(err_cnt_inc) >= UNLOCK_ERRS) begin
                            // Relock restarts at the offset that was in use.
                            state_q     <= ST_SEARCH;
                            err_cnt_q   <= 4'd0;
                            match_cnt_q <= 8'd0;
                            skip_q      <= 1'b1;
                            loss_q      <= 1'b1;
                        end else begin
                            err_cnt_q <= err_cnt_inc;
                        end
                    end
                    default: begin
                        state_q <= ST_SEARCH;
                        skip_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    // History and output datapath.
    always_ff @(posedge clkPara or negedge resetN) begin
        if (!resetN) begin
            wprev_q    <= 8'h00;
            wcur_q     <= 8'h00;
            upd_q      <= 1'b0;
            dout_q     <= 8'h00;
            dout_vld_q <= 1'b0;
        end else begin
            upd_q      <= dinValid;
            dout_vld_q <= upd_q;
            if (dinValid) begin
                wprev_q <= wcur_q;
                wcur_q  <= din;
            end
            if (upd_q) begin
                dout_q <= hist_win;
            end
        end
    end

    assign dout       = dout_q;
    assign doutValid  = dout_vld_q;
    assign locked     = (state_q == ST_LOCKED);
    assign offset     = offset_q;
    assign lossOfLock = loss_q;

endmodule

// File: tb/tb_iserdes_word_align.sv
module tb_iserdes_word_align;

    logic       clkPara = 1'b0;
    logic       resetN;
    logic [7:0] din;
    logic       dinValid;
    logic       trainEn;
    logic       realign;
    logic [7:0] dout;
    logic       doutValid;
    logic       locked;
    logic [2:0] offset;
    logic       lossOfLock;

    int n_pass  = 0;
    int n_total = 0;
    int loss_seen = 0;

    iserdes_word_align dut (
        .clkPara   (clkPara),
        .resetN    (resetN),
        .din       (din),
        .dinValid  (dinValid),
        .trainEn   (trainEn),
        .realign   (realign),
        .dout      (dout),
        .doutValid (doutValid),
        .locked    (locked),
        .offset    (offset),
        .lossOfLock(lossOfLock)
    );

    always #5 clkPara = ~clkPara;

    typedef struct {
        logic [7:0] word;       // constant raw word = A5 rotated right by the true offset
        logic [2:0] exp_off;
        int         lock_edge;  // valid word on which locked rises
    } lock_vec_t;

    lock_vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step(input logic [7:0] d, input logic v, input logic t, input logic r);
        din = d; dinValid = v; trainEn = t; realign = r;
        @(posedge clkPara);
        #1;
        if (lossOfLock === 1'b1) loss_seen++;
    endtask

    task automatic do_reset();
        din = 8'h00; dinValid = 1'b0; trainEn = 1'b1; realign = 1'b0;
        resetN = 1'b0;
        @(posedge clkPara); #1;
        @(posedge clkPara); #1;
        @(negedge clkPara);
        resetN = 1'b1;
        loss_seen = 0;
    endtask

    logic [7:0] h0, h1, p, exp_w;
    int vcount;
    bit got, early;

    initial begin
        vecs[0] = '{word: 8'hA5, exp_off: 3'd0, lock_edge: 17};
        vecs[1] = '{word: 8'hB4, exp_off: 3'd3, lock_edge: 20};
        vecs[2] = '{word: 8'h2D, exp_off: 3'd5, lock_edge: 22};
        vecs[3] = '{word: 8'h4B, exp_off: 3'd7, lock_edge: 24};

        // Reset state
        din = 8'hFF; dinValid = 1'b1; trainEn = 1'b1; realign = 1'b0;
        resetN = 1'b0;
        #12;
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_dout_vld", 32'(doutValid), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_offset", 32'(offset), 32'h0);
        chk("rst_loss", 32'(lossOfLock), 32'h0);

        // Lock on constant shifted training streams
        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int i = 1; i < vecs[v].lock_edge; i++) step(vecs[v].word, 1'b1, 1'b1, 1'b0);
            chk($sformatf("v%0d_prelock", v), 32'(locked), 32'h0);
            step(vecs[v].word, 1'b1, 1'b1, 1'b0);
            chk($sformatf("v%0d_locked", v), 32'(locked), 32'h1);
            chk($sformatf("v%0d_offset", v), 32'(offset), 32'(vecs[v].exp_off));
            step(vecs[v].word, 1'b1, 1'b1, 1'b0);
            chk($sformatf("v%0d_dout", v), 32'(dout), 32'hA5);
            chk($sformatf("v%0d_dout_vld", v), 32'(doutValid), 32'h1);
            chk($sformatf("v%0d_no_loss", v), 32'(loss_seen), 32'h0);
        end

        // Error tolerance: B5 corrupts exactly one window at offset 3
        do_reset();
        repeat (20) step(8'hB4, 1'b1, 1'b1, 1'b0);
        chk("err_locked0", 32'(locked), 32'h1);
        repeat (3) step(8'hB5, 1'b1, 1'b1, 1'b0);
        repeat (4) step(8'hB4, 1'b1, 1'b1, 1'b0);
        chk("err3_locked", 32'(locked), 32'h1);
        chk("err3_no_loss", 32'(loss_seen), 32'h0);
        repeat (4) step(8'hB5, 1'b1, 1'b1, 1'b0);
        chk("err4_still_locked", 32'(locked), 32'h1);
        step(8'hB4, 1'b1, 1'b1, 1'b0);
        chk("err4_loss", 32'(lossOfLock), 32'h1);
        chk("err4_unlocked", 32'(locked), 32'h0);
        chk("err4_offset", 32'(offset), 32'h3);
        step(8'hB4, 1'b1, 1'b1, 1'b0);
        chk("err4_loss_one_cycle", 32'(lossOfLock), 32'h0);
        repeat (15) step(8'hB4, 1'b1, 1'b1, 1'b0);
        chk("relock_pre", 32'(locked), 32'h0);
        step(8'hB4, 1'b1, 1'b1, 1'b0);
        chk("relock", 32'(locked), 32'h1);
        chk("relock_offset", 32'(offset), 32'h3);

        // trainEn=0 payload: stays locked, dout = payload shifted by 3
        h0 = 8'hB4; h1 = 8'hB4;
        for (int i = 0; i < 10; i++) begin
            p = 8'($urandom_range(0, 255));
            step(p, 1'b1, 1'b0, 1'b0);
            exp_w = {h0[4:0], h1[7:5]};
            chk($sformatf("pay%0d_dout", i), 32'(dout), 32'(exp_w));
            h0 = h1; h1 = p;
        end
        chk("pay_locked", 32'(locked), 32'h1);
        chk("pay_no_loss", 32'(loss_seen), 32'h1);

        // realign on the 16th match of VERIFY
        do_reset();
        repeat (19) step(8'hB4, 1'b1, 1'b1, 1'b0);
        step(8'hB4, 1'b1, 1'b1, 1'b1);
        chk("rlg16_locked", 32'(locked), 32'h0);
        chk("rlg16_offset", 32'(offset), 32'h3);
        early = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(8'hB4, 1'b1, 1'b1, 1'b0);
            if (locked === 1'b1) early = 1'b1;
        end
        chk("rlg16_no_early_lock", 32'(early), 32'h0);
        step(8'hB4, 1'b1, 1'b1, 1'b0);
        chk("rlg16_relock", 32'(locked), 32'h1);
        // realign from LOCKED while dinValid=0
        step(8'hB4, 1'b0, 1'b1, 1'b1);
        chk("rlg_idle_loss", 32'(lossOfLock), 32'h1);
        chk("rlg_idle_unlocked", 32'(locked), 32'h0);
        step(8'hB4, 1'b0, 1'b1, 1'b0);
        chk("rlg_idle_loss_one", 32'(lossOfLock), 32'h0);

        // dinValid at 50%: same number of valid words to lock
        do_reset();
        vcount = 0; got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            step(8'hB4, (c % 2) == 0, 1'b1, 1'b0);
            if ((c % 2) == 0) vcount++;
            if (locked === 1'b1) got = 1'b1;
        end
        chk("gap_locked", 32'(got), 32'h1);
        chk("gap_words", 32'(vcount), 32'd20);
        chk("gap_offset", 32'(offset), 32'h3);

        // Reset mid-cycle while LOCKED
        do_reset();
        repeat (20) step(8'hB4, 1'b1, 1'b1, 1'b0);
        chk("mrst_pre_locked", 32'(locked), 32'h1);
        #3;
        resetN = 1'b0;
        #1;
        chk("mrst_outputs", 32'({dout, doutValid, locked, offset, lossOfLock}), 32'h0);
        @(posedge clkPara); #1;
        if (lossOfLock === 1'b1) loss_seen++;
        chk("mrst_no_loss", 32'(loss_seen), 32'h0);
        @(negedge clkPara);
        resetN = 1'b1;
        repeat (19) step(8'hB4, 1'b1, 1'b1, 1'b0);
        chk("mrst_prelock", 32'(locked), 32'h0);
        step(8'hB4, 1'b1, 1'b1, 1'b0);
        chk("mrst_relock", 32'(locked), 32'h1);
        chk("mrst_offset", 32'(offset), 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/iserdes_word_align.md
ISERDES_WORD_ALIGN -- requirements
Module: iserdes_word_align

Interface
REQ-001 SHALL have parameter TRAIN_PATTERN, default 8'hA5: training word; all 8 bit-rotations are distinct.
REQ-002 SHALL have parameter LOCK_COUNT, default 16: consecutive matches needed to declare lock (range 1..255).
REQ-003 SHALL have parameter UNLOCK_ERRS, default 4: consecutive mismatches in LOCKED with trainEn=1 that force relock (range 1..15).
REQ-004 SHALL have port clkPara  input  1  parallel-word clock; the only clock.
REQ-005 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port din  input  8  raw unaligned word from the deserializer; din[7] is the earliest received bit.
REQ-007 SHALL have port dinValid  input  1  din qualifier.
REQ-008 SHALL have port trainEn  input  1  far end is sending TRAIN_PATTERN; enables mismatch checking in LOCKED.
REQ-009 SHALL have port realign  input  1  single-cycle request to drop lock and restart search.
REQ-010 SHALL have port dout  output  8  aligned word, MSB = earliest bit.
REQ-011 SHALL have port doutValid  output  1  dout qualifier.
REQ-012 SHALL have port locked  output  1  high in LOCKED state only.
REQ-013 SHALL have port offset  output  3  current bit offset in use.
REQ-014 SHALL have port lossOfLock  output  1  one-cycle pulse on any LOCKED->SEARCH transition.

Function
REQ-015 SHALL keep history registers wPrev, wCur; on dinValid=1: wPrev<=wCur, wCur<=din; on dinValid=0 nothing in the block advances (state, counters, offset held).
REQ-016 SHALL form window = bits [15-offset : 8-offset] of {wPrev, wCur}; offset 0 selects wPrev unchanged.
REQ-017 SHALL register dout<=window and doutValid<=dinValid one cycle after each history update; din to dout latency = 2 valid words + 1 clkPara cycle.
REQ-018 SHALL output doutValid in all states; dout is meaningful only when locked=1.
REQ-019 SHALL implement FSM SEARCH, VERIFY, LOCKED; evaluation uses window of the current valid cycle.
REQ-020 SEARCH: window==TRAIN_PATTERN -> VERIFY, matchCnt=1; else offset<=offset+1 mod 8 (7 wraps to 0), stay.
REQ-021 SEARCH SHALL ignore the first valid word after entry (history not yet filled with post-offset data); wrap is unbounded, no timeout.
REQ-022 VERIFY: match -> matchCnt+1; when matchCnt reaches LOCK_COUNT -> LOCKED (LOCK_COUNT=1 locks on the entering match); mismatch -> SEARCH, offset+1 mod 8, matchCnt=0.
REQ-023 LOCKED: offset frozen; trainEn=1 and mismatch -> errCnt+1, match -> errCnt=0; errCnt reaching UNLOCK_ERRS -> SEARCH with offset unchanged; trainEn=0 -> errCnt held at 0, never unlocks on data.
REQ-024 realign=1 SHALL force SEARCH next cycle from any state, clear matchCnt/errCnt, keep offset; it overrides every simultaneous data-driven transition, and is acted on even when dinValid=0.
REQ-025 lossOfLock SHALL pulse for exactly one cycle on LOCKED->SEARCH by either cause; never from SEARCH or VERIFY.
REQ-026 matchCnt and errCnt SHALL saturate and never wrap.

Reset
REQ-027 resetN=0 SHALL immediately clear: state=SEARCH, offset=0, wPrev=wCur=0, matchCnt=errCnt=0, dout=8'h00, doutValid=0, locked=0, lossOfLock=0.
REQ-028 Reset assertion mid-VERIFY or mid-LOCKED SHALL abort without lossOfLock pulse; release is synchronous to clkPara, first valid word after release is history fill only.

Verification
REQ-029 Continuous A5 stream shifted by 3 bits, dinValid=1 -> locked rises after search + 16 matches, offset=3, dout=8'hA5 every cycle.
REQ-030 Stream with true offset 0 after reset passing through offsets 1..7 first? No: offset 0 aligned -> locked with offset=0; true offset 7 -> offset walks 0..7, locks at 7 without wrap error.
REQ-031 Locked, trainEn=1, inject 3 bad words then good -> stays locked; inject 4 consecutive bad -> lossOfLock one-cycle pulse, locked=0, relock at same offset.
REQ-032 Locked with random payload, trainEn=0 -> locked stays 1, dout equals payload shifted by offset, latency per REQ-017.
REQ-033 realign asserted in same cycle as VERIFY's 16th match -> state SEARCH, locked never rises; dinValid toggled 50% during search -> lock takes exactly same number of valid words.
REQ-034 resetN pulled low while LOCKED, mid-cycle -> all outputs zero immediately, no lossOfLock, relock after release.
